data_writeback: RTL and testbench

- Write-back engine; the write-side counterpart of the fetch path.
- Accepts a stream of result words from the array output via a valid/ready handshake.
- Issues one SRAM write per word at dst_addr + channel_index*row + row_index, row-major within channel.
- Sits between the array drain logic and the shared SRAM port; signals done when the programmed channel x row tile is fully written.

---
 rtl/data_writeback_pkg.sv | 36 +++
 rtl/data_writeback_if.sv | 32 +++
 rtl/idx2d_counter.sv | 45 ++++
 rtl/data_writeback.sv | 96 +++++++++
 tb/tb_data_writeback.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_writeback_pkg.sv
// Shared definitions for the write-back engine: widths, FSM encoding, latched tile
// configuration and the tile address helper. The fetch path uses the same constants.
package data_writeback_pkg;

    localparam int WORD_ADDR_BITS = 16;
    localparam int DATA_MAX_BITS  = 8;
    localparam int DATA_BITS      = 32;

    localparam logic WEN_READ  = 1'b0;
    localparam logic WEN_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FINISH
    } wb_state_t;

    typedef struct packed {
        logic [WORD_ADDR_BITS-1:0] base;
        logic [DATA_MAX_BITS-1:0]  channel;
        logic [DATA_MAX_BITS-1:0]  row;
    } wb_cfg_t;

    // Row-major within channel; the sum wraps modulo the SRAM address space.
    function automatic logic [WORD_ADDR_BITS-1:0] tile_addr(
        input logic [WORD_ADDR_BITS-1:0] base,
        input logic [DATA_MAX_BITS-1:0]  ch_idx,
        input logic [DATA_MAX_BITS-1:0]  row,
        input logic [DATA_MAX_BITS-1:0]  row_idx
    );
        logic [2*DATA_MAX_BITS-1:0] prod;
        prod = (2*DATA_MAX_BITS)'(ch_idx) * (2*DATA_MAX_BITS)'(row);
        return base + WORD_ADDR_BITS'(prod) + WORD_ADDR_BITS'(row_idx);
    endfunction

endpackage

// File: rtl/data_writeback_if.sv
// Handshake, configuration and SRAM-side signals of the write-back engine.
// master = array drain / controller side, slave = the engine itself.
interface data_writeback_if;
    import data_writeback_pkg::*;

    logic                      start;
    logic                      abort;
    logic [WORD_ADDR_BITS-1:0] dst_addr;
    logic [DATA_MAX_BITS-1:0]  channel;
    logic [DATA_MAX_BITS-1:0]  row;
    logic                      in_valid;
    logic [DATA_BITS-1:0]      in_data;
    logic                      in_ready;
    logic                      wen;
    logic [WORD_ADDR_BITS-1:0] addr_out;
    logic [DATA_BITS-1:0]      data_out;
    logic                      busy;
    logic                      done;
    logic [DATA_MAX_BITS-1:0]  row_index;
    logic [DATA_MAX_BITS-1:0]  channel_index;

    modport master (
        output start, abort, dst_addr, channel, row, in_valid, in_data,
        input  in_ready, wen, addr_out, data_out, busy, done, row_index, channel_index
    );

    modport slave (
        input  start, abort, dst_addr, channel, row, in_valid, in_data,
        output in_ready, wen, addr_out, data_out, busy, done, row_index, channel_index
    );

endinterface

// File: rtl/idx2d_counter.sv
// Two-level channel x row index counter, row innermost. last flags the final
// position of the tile so the caller can finish on the same beat.
module idx2d_counter
    import data_writeback_pkg::*;
#(
    parameter int W = DATA_MAX_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] row_limit,
    input  logic [W-1:0] ch_limit,
    output logic [W-1:0] row_idx,
    output logic [W-1:0] ch_idx,
    output logic         last
);

    logic row_wrap;

    assign row_wrap = (row_idx == row_limit - W'(1));
    assign last     = row_wrap && (ch_idx == ch_limit - W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_idx <= '0;
            ch_idx  <= '0;
        end else if (clear) begin
            row_idx <= '0;
            ch_idx  <= '0;
        end else if (enable) begin
            // NOTE: non-blocking so every branch sees the pre-edge indices.
            if (last) begin
                row_idx <= '0;
                ch_idx  <= '0;
            end else if (row_wrap) begin
                row_idx <= '0;
                ch_idx  <= ch_idx + W'(1);
            end else begin
                row_idx <= row_idx + W'(1);
            end
        end
    end

endmodule

// File: rtl/data_writeback.sv
// Write-back engine: drains result words into SRAM at base + ch*row + row_idx,
// one write per accepted beat with one cycle of latency, then pulses done.
module data_writeback
    import data_writeback_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    data_writeback_if.slave    bus
);

    wb_state_t                 state;
    wb_cfg_t                   cfg;
    logic                      start_ok;
    logic                      abort_act;
    logic                      accept;
    logic                      last;
    logic [DATA_MAX_BITS-1:0]  row_idx;
    logic [DATA_MAX_BITS-1:0]  ch_idx;
    logic [WORD_ADDR_BITS-1:0] wr_addr;

    assign start_ok  = (state == ST_IDLE) && bus.start;
    assign abort_act = bus.abort && (state != ST_IDLE);

    // A beat offered together with abort is refused rather than silently dropped.
    assign bus.in_ready = (state == ST_WRITE) && !bus.abort;
    assign bus.busy     = (state == ST_WRITE);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.row_index     = row_idx;
    assign bus.channel_index = ch_idx;

    assign wr_addr = tile_addr(cfg.base, ch_idx, cfg.row, row_idx);

    idx2d_counter #(
        .W (DATA_MAX_BITS)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok || abort_act),
        .enable    (accept),
        .row_limit (cfg.row),
        .ch_limit  (cfg.channel),
        .row_idx   (row_idx),
        .ch_idx    (ch_idx),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cfg          <= '0;
            bus.wen      <= WEN_READ;
            bus.addr_out <= '0;
            bus.data_out <= '0;
            bus.done     <= 1'b0;
        end else begin
            bus.wen  <= WEN_READ;
            bus.done <= 1'b0;

            // Address and data hold their last value on idle cycles.
            if (accept) begin
                bus.wen      <= WEN_WRITE;
                bus.addr_out <= wr_addr;
                bus.data_out <= bus.in_data;
            end

            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cfg.base    <= bus.dst_addr;
                        cfg.channel <= bus.channel;
                        cfg.row     <= bus.row;
                        if (bus.channel == '0 || bus.row == '0) begin
                            state    <= ST_FINISH;
                            bus.done <= 1'b1;
                        end else begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (accept && last) begin
                        // done rises with the final write so both land in the same cycle.
                        state    <= ST_FINISH;
                        bus.done <= 1'b1;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_writeback.sv
// Directed bench for data_writeback: expected SRAM writes are queued as beats are
// driven and checked in order by a monitor whenever wen is seen high.
module tb_data_writeback;
    import data_writeback_pkg::*;

    typedef struct packed {
        logic [WORD_ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0]      data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   wr_count = 0;
    int   w0;
    wr_t  sb[$];
    wr_t  mon_exp;

    always #5 clk = ~clk;

    data_writeback_if dif ();

    data_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] base, input logic [7:0] ch, input logic [7:0] rw);
        dif.dst_addr = base;
        dif.channel  = ch;
        dif.row      = rw;
        dif.start    = 1'b1;
        tick();
        dif.start    = 1'b0;
    endtask

    task automatic beat(input logic [15:0] a, input logic [31:0] d);
        dif.in_valid = 1'b1;
        dif.in_data  = d;
        sb.push_back('{addr: a, data: d});
        tick();
    endtask

    // Scoreboard monitor: every SRAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dif.wen === 1'b1) begin
            wr_count++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                check("wr_addr", 32'(dif.addr_out), 32'(mon_exp.addr));
                check("wr_data", dif.data_out, mon_exp.data);
            end
        end
    end

    initial begin
        dif.start    = 1'b0;
        dif.abort    = 1'b0;
        dif.dst_addr = '0;
        dif.channel  = '0;
        dif.row      = '0;
        dif.in_valid = 1'b0;
        dif.in_data  = '0;
        tick();
        tick();

        // Reset state
        check("rst_wen",      32'(dif.wen), 32'd0);
        check("rst_busy",     32'(dif.busy), 32'd0);
        check("rst_done",     32'(dif.done), 32'd0);
        check("rst_in_ready", 32'(dif.in_ready), 32'd0);
        check("rst_addr",     32'(dif.addr_out), 32'd0);
        check("rst_row_idx",  32'(dif.row_index), 32'd0);
        check("rst_ch_idx",   32'(dif.channel_index), 32'd0);
        rst = 1'b1;
        tick();

        // Basic tile 2 x 3 at 0x0100, continuous valid
        w0 = wr_count;
        do_start(16'h0100, 8'd2, 8'd3);
        check("basic_busy",     32'(dif.busy), 32'd1);
        check("basic_in_ready", 32'(dif.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            beat(16'h0100 + 16'(i), 32'(i + 1));
            if (i == 3) begin
                check("basic_row_idx", 32'(dif.row_index), 32'd1);
                check("basic_ch_idx",  32'(dif.channel_index), 32'd1);
            end
        end
        check("basic_done",      32'(dif.done), 32'd1);
        check("basic_last_wen",  32'(dif.wen), 32'd1);
        check("basic_busy_fin",  32'(dif.busy), 32'd0);
        check("basic_ready_fin", 32'(dif.in_ready), 32'd0);
        dif.in_valid = 1'b0;
        tick();
        check("basic_done_1cyc", 32'(dif.done), 32'd0);
        check("basic_wr_count",  32'(wr_count - w0), 32'd6);

        // Backpressure: valid alternates, writes follow only accepted beats
        w0 = wr_count;
        do_start(16'h0100, 8'd2, 8'd3);
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                beat(16'h0100 + 16'(i / 2), 32'h50 + 32'(i / 2));
            end else begin
                dif.in_valid = 1'b0;
                tick();
                check("bp_gap_wen", 32'(dif.wen), 32'd0);
            end
            if (i == 10) check("bp_done", 32'(dif.done), 32'd1);
        end
        check("bp_wr_count", 32'(wr_count - w0), 32'd6);

        // Zero dimension: no writes, immediate done
        w0 = wr_count;
        do_start(16'h0040, 8'd4, 8'd0);
        check("zero_done", 32'(dif.done), 32'd1);
        check("zero_wen",  32'(dif.wen), 32'd0);
        check("zero_busy", 32'(dif.busy), 32'd0);
        tick();
        check("zero_done_1cyc", 32'(dif.done), 32'd0);
        tick();
        tick();
        check("zero_wr_count", 32'(wr_count - w0), 32'd0);

        // Abort after 3 beats; the beat coinciding with abort is dropped
        w0 = wr_count;
        do_start(16'h0200, 8'd2, 8'd4);
        for (int i = 0; i < 3; i++) beat(16'h0200 + 16'(i), 32'hA0 + 32'(i));
        dif.in_valid = 1'b1;
        dif.in_data  = 32'hDEAD;
        dif.abort    = 1'b1;
        tick();
        dif.abort    = 1'b0;
        dif.in_valid = 1'b0;
        check("abort_in_ready", 32'(dif.in_ready), 32'd0);
        check("abort_busy",     32'(dif.busy), 32'd0);
        check("abort_wen",      32'(dif.wen), 32'd0);
        check("abort_row_idx",  32'(dif.row_index), 32'd0);
        check("abort_ch_idx",   32'(dif.channel_index), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 32'(dif.done), 32'd0);
        end
        check("abort_wr_count", 32'(wr_count - w0), 32'd3);
        do_start(16'h0200, 8'd1, 8'd2);
        beat(16'h0200, 32'hB0);
        beat(16'h0201, 32'hB1);
        check("restart_done", 32'(dif.done), 32'd1);
        dif.in_valid = 1'b0;
        tick();

        // Asynchronous reset mid-tile
        w0 = wr_count;
        do_start(16'h0300, 8'd2, 8'd2);
        beat(16'h0300, 32'hC0);
        beat(16'h0301, 32'hC1);
        dif.in_data = 32'hC2;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_wen",      32'(dif.wen), 32'd0);
        check("arst_busy",     32'(dif.busy), 32'd0);
        check("arst_done",     32'(dif.done), 32'd0);
        check("arst_in_ready", 32'(dif.in_ready), 32'd0);
        check("arst_addr",     32'(dif.addr_out), 32'd0);
        check("arst_data",     dif.data_out, 32'd0);
        check("arst_row_idx",  32'(dif.row_index), 32'd0);
        check("arst_ch_idx",   32'(dif.channel_index), 32'd0);
        tick();
        tick();
        dif.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("arst_busy_after", 32'(dif.busy), 32'd0);
        check("arst_wr_count",   32'(wr_count - w0), 32'd2);

        // Address wrap; a start during the tile must be ignored
        w0 = wr_count;
        do_start(16'hFFFE, 8'd1, 8'd4);
        beat(16'hFFFE, 32'h11);
        dif.start    = 1'b1;
        dif.dst_addr = 16'h0000;
        dif.channel  = 8'd9;
        dif.row      = 8'd9;
        beat(16'hFFFF, 32'h12);
        dif.start    = 1'b0;
        beat(16'h0000, 32'h13);
        beat(16'h0001, 32'h14);
        check("wrap_done",     32'(dif.done), 32'd1);
        check("wrap_last_wen", 32'(dif.wen), 32'd1);
        check("wrap_last_addr", 32'(dif.addr_out), 32'h0001);
        dif.in_valid = 1'b0;
        tick();
        check("wrap_done_1cyc", 32'(dif.done), 32'd0);
        check("wrap_busy_after", 32'(dif.busy), 32'd0);
        tick();
        check("wrap_wr_count", 32'(wr_count - w0), 32'd4);

        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
